// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle between the decode stage and
// the registered ALU.
//   master : decode side / consumer side (drives operands, op, out_ready)
//   slave  : alu_pipe (drives in_ready, result and status flags)
// Signals: in_valid/in_ready/in_a/in_b/op on the request side,
//          out_valid/out_ready/out/zero/carry/overflow/negative/err on the
//          result side.
interface alu_pipe_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         negative;
  logic         err;

  modport master (
    output in_valid, in_a, in_b, op, out_ready,
    input  in_ready, out_valid, out, zero, carry, overflow, negative, err
  );

  modport slave (
    input  in_valid, in_a, in_b, op, out_ready,
    output in_ready, out_valid, out, zero, carry, overflow, negative, err
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered, handshaked N-bit ALU with status flags.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_pipe_if.slave (operands/op in, result/flags out, valid/ready
//          on both sides)
// One operation is in flight at a time. Single-cycle ops have latency 1.
// Optional macro ALU_PIPE_MUL_EN adds a shift-add multiplier (op 1001,
// latency N+1); without it op 1001 reports err like any illegal opcode.
module alu_pipe #(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input logic     clk,
  input logic     rst,
  alu_pipe_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1110;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1001;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd1;
`endif
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] out_q, out_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic         ovf_q, ovf_d;
  logic         neg_q, neg_d;
  logic         err_q, err_d;
  logic         out_valid_q, out_valid_d;

`ifdef ALU_PIPE_MUL_EN
  // Counter runs 0..N: N shift-add steps, then one cycle to load the result.
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(N);
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [SHW:0]   cnt_q, cnt_d;
`endif

  logic           accept;
  logic           transfer;
  logic [SHW-1:0] shamt;
  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [N-1:0]   alu_res;
  logic           alu_c;
  logic           alu_v;
  logic           alu_err;
  logic           is_mul;

  assign bus.in_ready  = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign transfer      = out_valid_q && bus.out_ready;
  assign shamt         = bus.in_b[SHW-1:0];
  assign sum           = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  // diff[N] is the unsigned borrow, i.e. a < b
  assign diff          = {1'b0, bus.in_a} - {1'b0, bus.in_b};

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.negative  = neg_q;
  assign bus.err       = err_q;

  // Single-cycle datapath, evaluated on the presented operands.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
    case (bus.op)
      OP_AND:  alu_res = bus.in_a & bus.in_b;
      OP_OR:   alu_res = bus.in_a | bus.in_b;
      OP_NOR:  alu_res = ~(bus.in_a | bus.in_b);
      OP_ADD: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (bus.in_a[N-1] == bus.in_b[N-1]) && (sum[N-1] != bus.in_a[N-1]);
      end
      OP_SUB: begin
        alu_res = diff[N-1:0];
        alu_c   = diff[N];
        alu_v   = (bus.in_a[N-1] != bus.in_b[N-1]) && (diff[N-1] != bus.in_a[N-1]);
      end
      OP_SLT:  alu_res = {{(N-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
      OP_SLTU: alu_res = {{(N-1){1'b0}}, diff[N]};
      OP_SLL:  alu_res = bus.in_a << shamt;
      OP_SRL:  alu_res = bus.in_a >> shamt;
      OP_SRA:  alu_res = $signed(bus.in_a) >>> shamt;
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  is_mul = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  // Control and result registers. Results and flags only change on an
  // accepted single-cycle op or on multiplier completion, so they stay
  // stable while the consumer stalls.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    neg_d       = neg_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
`ifdef ALU_PIPE_MUL_EN
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
`endif
    if (transfer) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
`ifdef ALU_PIPE_MUL_EN
            state_d     = S_MUL;
            out_valid_d = 1'b0;
            mcand_d     = {{N{1'b0}}, bus.in_a};
            mplier_d    = bus.in_b;
            acc_d       = '0;
            cnt_d       = '0;
`endif
          end else begin
            out_d       = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_c;
            ovf_d       = alu_v;
            neg_d       = alu_res[N-1];
            err_d       = alu_err;
            out_valid_d = 1'b1;
          end
        end
      end
`ifdef ALU_PIPE_MUL_EN
      S_MUL: begin
        if (cnt_q != CNT_LAST) begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + (SHW+1)'(1);
        end else begin
          out_d       = acc_q[N-1:0];
          zero_d      = (acc_q[N-1:0] == '0);
          carry_d     = |acc_q[2*N-1:N];
          ovf_d       = 1'b0;
          neg_d       = acc_q[N-1];
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
`endif
      S_HOLD: begin
        if (transfer) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset aborts any multiply in progress and drops a pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_PIPE_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (N=32). Expected results are
// computed by a reference function when an op is accepted and compared when
// the DUT hands the result over. Define ALU_PIPE_MUL_EN to exercise the
// multiplier build.
module tb_alu_pipe;
  localparam int N = 32;

  typedef struct packed {
    logic [N-1:0] res;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         neg;
    logic         err;
  } exp_t;

  logic clk;
  logic rst;
  int   passCount;
  int   checkCount;
  bit   randReady;
  exp_t sb[$];

  alu_pipe_if #(.N(N)) bus ();

  alu_pipe #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Reference model written with wide signed arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [N-1:0] a,
                                 input logic [N-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sbv;
    longint      wide;
    logic [63:0] prod;
    logic [4:0]  amt;
    e    = '0;
    amt  = b[4:0];
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    prod = '0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin
        e.res   = a + b;
        e.carry = ({32'b0, a} + {32'b0, b}) > 64'h0000_0000_FFFF_FFFF;
        wide    = sa + sbv;
        e.ovf   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0110: begin
        e.res   = a - b;
        e.carry = (a < b);
        wide    = sa - sbv;
        e.ovf   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0111: e.res = (sa < sbv) ? 32'd1 : 32'd0;
      4'b0011: e.res = (a < b) ? 32'd1 : 32'd0;
      4'b0100: e.res = a << amt;
      4'b0101: e.res = a >> amt;
      4'b1110: e.res = $signed(a) >>> amt;
`ifdef ALU_PIPE_MUL_EN
      4'b1001: begin
        prod    = {32'b0, a} * {32'b0, b};
        e.res   = prod[31:0];
        e.carry = (prod[63:32] != 32'b0);
      end
`endif
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == '0);
    e.neg  = e.res[N-1];
    return e;
  endfunction

  // Presents one op, waits (bounded) for the accepting edge, records the
  // expected result and returns #1 after that edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [N-1:0] a,
                               input logic [N-1:0] b);
    int waitCycles;
    bit done;
    waitCycles   = 0;
    done         = 1'b0;
    bus.op       = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    while (!done && waitCycles < 300) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(op, a, b));
        done = 1'b1;
      end else begin
        waitCycles++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) checkOutput("acceptTimeout", 64'(waitCycles), 64'd0);
  endtask

  task automatic drainScoreboard();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  // Result monitor: a handover happens at the posedge following a negedge
  // where out_valid && out_ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedResult", 64'(bus.out), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          checkOutput("result", 64'(bus.out), 64'(e.res));
          checkOutput("flags",
                      64'({bus.zero, bus.carry, bus.overflow, bus.negative, bus.err}),
                      64'({e.zero, e.carry, e.ovf, e.neg, e.err}));
        end
      end
    end
  end

  // Random consumer back-pressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [3:0] rop;
    int         k;
    bit         staleSeen;
    passCount     = 0;
    checkCount    = 0;
    randReady     = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.op        = 4'b0000;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rstOutValid", 64'(bus.out_valid), 64'd0);
    checkOutput("rstInReady", 64'(bus.in_ready), 64'd1);
    checkOutput("rstOut", 64'(bus.out), 64'd0);
    checkOutput("rstFlags",
                64'({bus.zero, bus.carry, bus.overflow, bus.negative, bus.err}),
                64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] directed arithmetic/shift ops");
    applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'h1);
    checkOutput("addLatency", 64'(bus.out_valid), 64'd1);
    applyStimulus(4'b0110, 32'h8000_0000, 32'h1);
    applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'h1);
    applyStimulus(4'b0011, 32'hFFFF_FFFF, 32'h1);
    applyStimulus(4'b1110, 32'h8000_0010, 32'h0000_0124);
    applyStimulus(4'b0101, 32'h8000_0010, 32'h0000_0124);
    applyStimulus(4'b0100, 32'h0000_0003, 32'h0000_0020);
    applyStimulus(4'b0110, 32'h0000_0001, 32'h0000_0002);
    applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'h1);
    drainScoreboard();

    $display("[TB] back-pressure hold");
    bus.out_ready = 1'b0;
    applyStimulus(4'b0010, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      checkOutput("holdOut", 64'(bus.out), 64'd7);
      checkOutput("holdInReady", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    applyStimulus(4'b1100, 32'd0, 32'd0);
    checkOutput("norSameEdge", 64'(bus.out), 64'hFFFF_FFFF);
    drainScoreboard();

    $display("[TB] illegal ops");
    applyStimulus(4'b1111, 32'h1234, 32'h5678);
    applyStimulus(4'b1001, 32'h0001_0000, 32'h0001_0000);
    applyStimulus(4'b0000, 32'hF0, 32'h3C);
    drainScoreboard();

`ifdef ALU_PIPE_MUL_EN
    $display("[TB] multiplier latency and reset abort");
    applyStimulus(4'b1001, 32'h0001_0000, 32'h0001_0000);
    k = 0;
    while (!bus.out_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("mulLatency", 64'(k), 64'd33);
    drainScoreboard();

    applyStimulus(4'b1001, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abortOutValid", 64'(bus.out_valid), 64'd0);
    checkOutput("abortInReady", 64'(bus.in_ready), 64'd1);
    staleSeen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) staleSeen = 1'b1;
    end
    checkOutput("noStale", 64'(staleSeen), 64'd0);
`endif

    $display("[TB] random ops with random back-pressure");
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      applyStimulus(rop, $urandom, $urandom);
    end
    randReady     = 1'b0;
    #1;
    bus.out_ready = 1'b1;
    drainScoreboard();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
